// File: rtl/text_writer.sv
// text_writer: sole writer of the character text RAM. Accepts an ASCII byte
// stream over valid/ready, keeps a cursor, and turns bytes into RAM writes.
// Control bytes: CR, LF, BS, FF (clear screen). No scrolling; rows wrap.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | in_ready high; a handshake latches the byte and moves to EXEC
//   EXEC  | one cycle; the byte's write is on the port, cursor is updated
//   CLEAR | busy high; one space written per cycle to every cell, 0..last
//
// The first cycle after reset release is a boot cycle: all outputs still hold
// their reset values while the FSM decides between CLEAR and IDLE. This lets
// the first CLEAR cycle already carry a write without exposing busy/in_ready
// while rstn is low.
module text_writer #(
  parameter int COLS           = 80,
  parameter int ROWS           = 30,
  parameter int addr_width     = 12,
  parameter int data_width     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [addr_width-1:0] waddr,
  output logic [data_width-1:0] wdata,
  output logic                  write_en,
  output logic [6:0]            cur_col,
  output logic [4:0]            cur_row,
  output logic                  busy
);

  if ((1 << addr_width) < COLS * ROWS) begin : g_bad_cfg
    $error("text_writer: addr_width too small for COLS*ROWS");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [6:0]            COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]            ROW_LAST  = 5'(ROWS - 1);
  localparam logic [addr_width-1:0] ADDR_LAST = addr_width'(COLS * ROWS - 1);
  localparam logic [addr_width-1:0] ROW_STEP  = addr_width'(COLS);
  localparam logic [addr_width-1:0] ADDR_ONE  = addr_width'(1);
  localparam logic [data_width-1:0] SPACE     = data_width'(8'h20);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  state_t                  state_q;
  logic                    init_q;
  logic [7:0]              byte_q;
  logic [6:0]              col_q;
  logic [4:0]              row_q;
  logic [addr_width-1:0]   row_base_q;
  logic                    we_q;
  logic [addr_width-1:0]   waddr_q;
  logic [data_width-1:0]   wdata_q;

  logic                    print_in;
  logic                    print_q;
  logic                    col_wrap;
  logic [addr_width-1:0]   cur_addr;
  logic [addr_width-1:0]   bs_addr;
  logic [4:0]              row_d;
  logic [addr_width-1:0]   row_base_d;

  // Byte classification, cursor address (row_base + col) and next-row values.
  always_comb begin
    print_in   = (in_data >= 8'h20) && (in_data <= 8'h7E);
    print_q    = (byte_q >= 8'h20) && (byte_q <= 8'h7E);
    col_wrap   = (col_q == COL_LAST);
    cur_addr   = row_base_q + addr_width'(col_q);
    bs_addr    = row_base_q + addr_width'(col_q - 7'd1);
    row_d      = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
    row_base_d = (row_q == ROW_LAST) ? '0 : row_base_q + ROW_STEP;
  end

  // Main FSM: latches bytes, registers the RAM write port, moves the cursor.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      init_q     <= 1'b0;
      byte_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (!init_q) begin
        init_q <= 1'b1;
        if (CLEAR_ON_RESET) begin
          state_q <= CLEAR;
          we_q    <= 1'b1;
          waddr_q <= '0;
          wdata_q <= SPACE;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (in_valid) begin
              byte_q  <= in_data;
              state_q <= EXEC;
              // The write lands in the EXEC cycle, so it is set up here.
              if (print_in) begin
                we_q    <= 1'b1;
                waddr_q <= cur_addr;
                wdata_q <= data_width'(in_data);
              end else if (in_data == CH_BS && col_q != 7'd0) begin
                we_q    <= 1'b1;
                waddr_q <= bs_addr;
                wdata_q <= SPACE;
              end
            end
          end
          EXEC: begin
            state_q <= IDLE;
            if (print_q) begin
              if (col_wrap) begin
                col_q      <= '0;
                row_q      <= row_d;
                row_base_q <= row_base_d;
              end else begin
                col_q <= col_q + 7'd1;
              end
            end else begin
              case (byte_q)
                CH_CR: col_q <= '0;
                CH_LF: begin
                  col_q      <= '0;
                  row_q      <= row_d;
                  row_base_q <= row_base_d;
                end
                CH_BS: begin
                  if (col_q != 7'd0) col_q <= col_q - 7'd1;
                end
                CH_FF: begin
                  state_q <= CLEAR;
                  we_q    <= 1'b1;
                  waddr_q <= '0;
                  wdata_q <= SPACE;
                end
                default: ;
              endcase
            end
          end
          CLEAR: begin
            // waddr_q doubles as the clear counter.
            if (waddr_q == ADDR_LAST) begin
              state_q    <= IDLE;
              col_q      <= '0;
              row_q      <= '0;
              row_base_q <= '0;
            end else begin
              we_q    <= 1'b1;
              waddr_q <= waddr_q + ADDR_ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready = init_q && (state_q == IDLE);
  assign busy     = (state_q == CLEAR);
  assign write_en = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cur_col  = col_q;
  assign cur_row  = row_q;

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer on a 4x2 screen: directed scenarios plus a random
// byte stream checked against a linear-screen reference model.
module tb_text_writer;
  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int NCELL = COLS * ROWS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, rstn2;
  logic [7:0]  in_data, in_data2;
  logic        in_valid, in_valid2;
  logic        in_ready, in_ready2;
  logic [11:0] waddr, waddr2;
  logic [7:0]  wdata, wdata2;
  logic        write_en, write_en2;
  logic [6:0]  cur_col, cur_col2;
  logic [4:0]  cur_row, cur_row2;
  logic        busy, busy2;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .addr_width(12), .data_width(8),
                .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .waddr(waddr), .wdata(wdata), .write_en(write_en),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy));

  text_writer #(.COLS(COLS), .ROWS(ROWS), .addr_width(12), .data_width(8),
                .CLEAR_ON_RESET(1'b0)) dut2 (
    .clk(clk), .rstn(rstn2), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .waddr(waddr2), .wdata(wdata2), .write_en(write_en2),
    .cur_col(cur_col2), .cur_row(cur_row2), .busy(busy2));

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [7:0] mem  [NCELL];
  logic [7:0] mscr [NCELL];
  int mcol, mrow;

  // RAM image as seen from the write port
  always @(posedge clk) begin
    if (write_en === 1'b1) begin
      mem[int'(waddr) % NCELL] = wdata;
      wr_cnt++;
    end
  end

  task automatic model_clear();
    for (int i = 0; i < NCELL; i++) mscr[i] = 8'h20;
    mcol = 0;
    mrow = 0;
  endtask

  // Reference: screen as a flat array, cursor as (col,row).
  task automatic model_byte(input logic [7:0] b, output bit we, output int addr,
                            output logic [7:0] d);
    we = 0; addr = 0; d = 8'h00;
    if (b >= 8'h20 && b <= 8'h7E) begin
      addr = mrow * COLS + mcol;
      we = 1; d = b; mscr[addr] = b;
      mcol++;
      if (mcol == COLS) begin mcol = 0; mrow = (mrow + 1) % ROWS; end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mcol = 0; mrow = (mrow + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        addr = mrow * COLS + mcol;
        we = 1; d = 8'h20; mscr[addr] = 8'h20;
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_timeout in_ready=%b expected 1", tag, in_ready);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold, input string tag);
    bit ewe; int eaddr; logic [7:0] ed;
    model_byte(b, ewe, eaddr, ed);
    in_data = b; in_valid = 1'b1;
    wait_ready(tag);
    @(negedge clk);
    total++;
    if (write_en !== ewe || in_ready !== 1'b0 ||
        (ewe && (waddr !== 12'(eaddr) || wdata !== ed))) begin
      bad++;
      $display("FAIL %s exec byte=%h got we=%b addr=%0d data=%h rdy=%b expected we=%b addr=%0d data=%h rdy=0",
               tag, b, write_en, waddr, wdata, in_ready, ewe, eaddr, ed);
    end
    @(negedge clk);
    total++;
    if (cur_col !== 7'(mcol) || cur_row !== 5'(mrow)) begin
      bad++;
      $display("FAIL %s cursor byte=%h got (%0d,%0d) expected (%0d,%0d)",
               tag, b, cur_col, cur_row, mcol, mrow);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    int idx = 0;
    while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_timeout busy=%b expected 1", tag, busy);
    end
    while (busy === 1'b1 && idx < 40) begin
      total++;
      if (write_en !== 1'b1 || waddr !== 12'(idx) || wdata !== 8'h20 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s clear_write idx=%0d got we=%b addr=%0d data=%h rdy=%b expected we=1 addr=%0d data=20 rdy=0",
                 tag, idx, write_en, waddr, wdata, in_ready, idx);
      end
      idx++;
      @(negedge clk);
    end
    total++;
    if (idx != NCELL) begin
      bad++;
      $display("FAIL %s clear_len got %0d expected %0d", tag, idx, NCELL);
    end
    model_clear();
    total++;
    if (in_ready !== 1'b1 || write_en !== 1'b0 || cur_col !== 7'd0 || cur_row !== 5'd0) begin
      bad++;
      $display("FAIL %s after_clear got rdy=%b we=%b cursor=(%0d,%0d) expected rdy=1 we=0 cursor=(0,0)",
               tag, in_ready, write_en, cur_col, cur_row);
    end
  endtask

  task automatic check_cursor(input int c, input int r, input string tag);
    total++;
    if (cur_col !== 7'(c) || cur_row !== 5'(r)) begin
      bad++;
      $display("FAIL %s cursor got (%0d,%0d) expected (%0d,%0d)", tag, cur_col, cur_row, c, r);
    end
  endtask

  task automatic check_screen(input string tag);
    int diffs = 0;
    for (int i = 0; i < NCELL; i++) if (mem[i] !== mscr[i]) diffs++;
    total++;
    if (diffs != 0) begin
      bad++;
      $display("FAIL %s screen got %0d differing cells expected 0", tag, diffs);
    end
  endtask

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b0 || write_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got rdy=%b we=%b busy=%b expected 0 0 0", in_ready, write_en, busy);
    end
    total++;
    if (waddr !== 12'd0 || wdata !== 8'd0 || cur_col !== 7'd0 || cur_row !== 5'd0) begin
      bad++;
      $display("FAIL reset_data got addr=%0d data=%h cursor=(%0d,%0d) expected 0", waddr, wdata, cur_col, cur_row);
    end
    total++;
    if (in_ready2 !== 1'b0 || write_en2 !== 1'b0 || busy2 !== 1'b0 || waddr2 !== 12'd0) begin
      bad++;
      $display("FAIL reset_dut2 got rdy=%b we=%b busy=%b addr=%0d expected 0", in_ready2, write_en2, busy2, waddr2);
    end
  endtask

  task automatic test_clear_on_reset();
    rstn = 1'b1;
    wait_clear("t1_clear");
    check_screen("t1_screen");
  endtask

  task automatic test_no_clear_variant();
    int w = 0;
    rstn2 = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready2 !== 1'b1) begin
      bad++;
      $display("FAIL t6_noclear_ready got %b expected 1", in_ready2);
    end
    for (int i = 0; i < 10; i++) begin
      if (write_en2 !== 1'b0 || busy2 !== 1'b0) w++;
      @(negedge clk);
    end
    total++;
    if (w != 0) begin
      bad++;
      $display("FAIL t6_noclear_quiet got %0d cycles with write/busy expected 0", w);
    end
  endtask

  task automatic test_printable();
    send_byte(8'h41, 1'b1, "t2_A");
    send_byte(8'h42, 1'b0, "t2_B");
    check_cursor(2, 0, "t2_final");
  endtask

  task automatic test_wrap();
    send_byte(8'h0D, 1'b0, "t3_cr");
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i), 1'b1, "t3_first5");
    check_cursor(1, 1, "t3_mid");
    for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), 1'b1, "t3_next4");
    in_valid = 1'b0;
    check_cursor(1, 0, "t3_final");
    check_screen("t3_screen");
  endtask

  task automatic test_backspace();
    send_byte(8'h0A, 1'b0, "t4_lf0");
    send_byte(8'h78, 1'b0, "t4_x");
    send_byte(8'h79, 1'b0, "t4_y");
    check_cursor(2, 1, "t4_start");
    send_byte(8'h08, 1'b0, "t4_bs1");
    check_cursor(1, 1, "t4_bs1c");
    send_byte(8'h0D, 1'b0, "t4_cr");
    send_byte(8'h08, 1'b0, "t4_bs0");
    send_byte(8'h0A, 1'b0, "t4_lf");
    check_cursor(0, 0, "t4_final");
    check_screen("t4_screen");
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: b = 8'($urandom_range(32, 126));
        6: b = 8'h0D;
        7: b = 8'h0A;
        8: b = 8'h08;
        default: begin
          case ($urandom_range(0, 3))
            0: b = 8'h00;
            1: b = 8'h1B;
            2: b = 8'h7F;
            default: b = 8'($urandom_range(128, 255));
          endcase
        end
      endcase
      send_byte(b, bit'($urandom_range(0, 1)), "rand");
    end
    in_valid = 1'b0;
    check_screen("rand_screen");
  endtask

  task automatic test_form_feed();
    int w0;
    send_byte(8'h51, 1'b1, "t5_Q");
    in_data = 8'h0C; in_valid = 1'b1;
    wait_ready("t5_ff");
    w0 = wr_cnt;
    @(negedge clk);
    total++;
    if (write_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t5_exec got we=%b busy=%b expected 0 0", write_en, busy);
    end
    in_data = 8'h5A;
    wait_clear("t5_clear");
    total++;
    if (wr_cnt - w0 != NCELL) begin
      bad++;
      $display("FAIL t5_writes got %0d expected %0d", wr_cnt - w0, NCELL);
    end
    send_byte(8'h5A, 1'b0, "t5_Z");
    check_screen("t5_screen");
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    in_data = 8'h0C; in_valid = 1'b1;
    wait_ready("t6_ff");
    @(negedge clk);
    in_valid = 1'b0;
    while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1 || waddr !== 12'd3) begin
      bad++;
      $display("FAIL t6_fourth got busy=%b addr=%0d expected busy=1 addr=3", busy, waddr);
    end
    #2 rstn = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || write_en !== 1'b0 || in_ready !== 1'b0 || waddr !== 12'd0 ||
        wdata !== 8'd0 || cur_col !== 7'd0 || cur_row !== 5'd0) begin
      bad++;
      $display("FAIL t6_async got busy=%b we=%b rdy=%b addr=%0d data=%h expected all 0",
               busy, write_en, in_ready, waddr, wdata);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_clear("t6_restart");
    check_screen("t6_screen");
  endtask

  initial begin
    rstn = 1'b0; rstn2 = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    in_valid2 = 1'b0; in_data2 = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_clear_on_reset();
    test_no_clear_variant();
    test_printable();
    test_wrap();
    test_backspace();
    test_random();
    test_form_feed();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
